// File: rtl/morse_digit_sequencer.sv
// Buffers BCD digits and keys them onto led as ITU Morse; MORSE_WORD_GAP_EN adds a 7-unit word gap after the last digit.
// Latency: accept at E0 into an idle block -> led high after E2; in_ready drops only when the DEPTH-entry FIFO is full.
module morse_digit_sequencer #(
    parameter int UNIT_CYCLES = 25_000_000,
    parameter int DEPTH       = 4,
    parameter int CW          = 25
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [3:0]                   digit_in,
    output logic                         in_ready,
    input  logic                         abort,
    output logic                         led,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         bad_digit
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DOT_LAST   = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] DASH_LAST  = CW'(3 * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] CHAR_EARLY = CW'(3 * UNIT_CYCLES - 2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MARK,
        SPACE,
        CHARGAP
`ifdef MORSE_WORD_GAP_EN
        , WORDGAP
`endif
    } state_t;

    state_t          state, state_nxt;
    logic [3:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            push, pop;
    logic [CW-1:0]   cnt, cnt_last;
    logic            phase_done;
    logic [2:0]      sym_left, sym_left_nxt;
    logic [4:0]      pattern, pattern_nxt;

    // MSB-first symbol pattern, 1 = dash
    function automatic logic [4:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    encode = 5'b11111;
            4'd1:    encode = 5'b01111;
            4'd2:    encode = 5'b00111;
            4'd3:    encode = 5'b00011;
            4'd4:    encode = 5'b00001;
            4'd5:    encode = 5'b00000;
            4'd6:    encode = 5'b10000;
            4'd7:    encode = 5'b11000;
            4'd8:    encode = 5'b11100;
            4'd9:    encode = 5'b11110;
            default: encode = 5'b00000;
        endcase
    endfunction

    assign in_ready = (fifo_count != NW'(DEPTH));
    assign push     = in_valid && in_ready && (digit_in <= 4'd9) && !abort;
    assign pop      = (state == LOAD) && !abort;
    assign busy     = (state != IDLE) || (fifo_count != '0);

    always_comb begin
        cnt_last = DOT_LAST;
        case (state)
            MARK:    cnt_last = pattern[4] ? DASH_LAST : DOT_LAST;
            CHARGAP: cnt_last = DASH_LAST;
            default: cnt_last = DOT_LAST;
        endcase
    end

    assign phase_done = (cnt == cnt_last);

    always_comb begin
        state_nxt    = state;
        sym_left_nxt = sym_left;
        pattern_nxt  = pattern;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_count != '0) state_nxt = LOAD;
                end
                LOAD: begin
                    state_nxt    = MARK;
                    pattern_nxt  = encode(mem[rd_ptr]);
                    sym_left_nxt = 3'd5;
                end
                MARK: begin
                    if (phase_done) begin
                        sym_left_nxt = sym_left - 3'd1;
                        state_nxt    = (sym_left > 3'd1) ? SPACE : CHARGAP;
                    end
                end
                SPACE: begin
                    if (phase_done) begin
                        pattern_nxt = {pattern[3:0], 1'b0};
                        state_nxt   = MARK;
                    end
                end
                CHARGAP: begin
                    // Leave one cycle early when a digit is waiting so the LOAD cycle
                    // falls inside the gap and the visible low stays exactly 3 units.
                    if ((fifo_count != '0) && (cnt >= CHAR_EARLY)) begin
                        state_nxt = LOAD;
                    end else if (phase_done) begin
`ifdef MORSE_WORD_GAP_EN
                        state_nxt    = WORDGAP;
                        sym_left_nxt = 3'd4;
`else
                        state_nxt    = IDLE;
`endif
                    end
                end
`ifdef MORSE_WORD_GAP_EN
                WORDGAP: begin
                    // four single-unit phases keep the counter inside the 3-unit range
                    if (phase_done) begin
                        sym_left_nxt = sym_left - 3'd1;
                        if (sym_left == 3'd1) state_nxt = IDLE;
                    end
                end
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sym_left  <= '0;
            pattern   <= '0;
            led       <= 1'b0;
            bad_digit <= 1'b0;
        end else begin
            state    <= state_nxt;
            sym_left <= sym_left_nxt;
            pattern  <= pattern_nxt;
            if ((state_nxt != state) || phase_done || (state == IDLE)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            led       <= (state_nxt == MARK);
            bad_digit <= in_valid && in_ready && (digit_in > 4'd9) && !abort;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (abort) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + NW'(1);
                2'b01:   fifo_count <= fifo_count - NW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= digit_in;
    end

endmodule

// File: tb/tb_morse_digit_sequencer.sv
// Scoreboard bench for morse_digit_sequencer: expected mark/gap lengths are queued per accepted digit.
module tb_morse_digit_sequencer;

    localparam int U = 4;
    localparam int D = 4;
    localparam int C = 8;
`ifdef MORSE_WORD_GAP_EN
    localparam int TAIL = 28;
`else
    localparam int TAIL = 12;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] digit_in = 4'd0;
    logic       abort = 1'b0;
    logic       in_ready, led, busy, bad_digit;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_marks[$];
    int exp_gaps[$];
    int obs_marks[$];
    int obs_gaps[$];
    int hi_len = 0;
    int lo_len = 0;
    int fall_cyc = 0;
    bit seen_fall = 0;
    bit led_q = 0;

    morse_digit_sequencer #(.UNIT_CYCLES(U), .DEPTH(D), .CW(C)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .digit_in(digit_in),
        .in_ready(in_ready), .abort(abort), .led(led), .busy(busy),
        .fifo_count(fifo_count), .bad_digit(bad_digit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Records completed mark lengths and the lows between marks of one busy period.
    always @(negedge clk) begin
        if (!rst) begin
            hi_len = 0; lo_len = 0; seen_fall = 0; led_q = 0;
        end else begin
            if (led) begin
                if (!led_q && seen_fall) obs_gaps.push_back(lo_len);
                hi_len++;
            end else begin
                if (led_q) begin
                    obs_marks.push_back(hi_len);
                    hi_len = 0; lo_len = 0; seen_fall = 1; fall_cyc = cyc;
                end
                lo_len++;
                if (!busy) seen_fall = 0;
            end
            led_q = led;
        end
    end

    function automatic bit is_dash(input int d, input int s);
        if (d == 0) return 1'b1;
        if (d <= 5) return (s >= d);
        return (s < d - 5);
    endfunction

    task automatic clear_sb();
        exp_marks.delete(); exp_gaps.delete(); obs_marks.delete(); obs_gaps.delete();
    endtask

    // Offer a digit until accepted; queue its expected keying on acceptance.
    task automatic send(input int d);
        bit ok, was_busy;
        ok = 0; was_busy = 0;
        @(negedge clk);
        in_valid = 1'b1; digit_in = 4'(d);
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (in_ready) begin
                was_busy = busy;
                @(posedge clk);
                ok = 1;
            end else begin
                @(negedge clk);
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_accept digit=%0d: in_ready stayed 0, required 1", d);
        end else begin
            if (was_busy) exp_gaps.push_back(3 * U);
            for (int s = 0; s < 5; s++) begin
                exp_marks.push_back(is_dash(d, s) ? 3 * U : U);
                if (s < 4) exp_gaps.push_back(U);
            end
        end
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL reset_led got=%b want=0", led); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (bad_digit !== 1'b0) begin errors++; $display("FAIL reset_bad got=%b want=0", bad_digit); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", in_ready); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_digit();
        logic [2:0] l;
        int rise_c;
        bit ok;
        clear_sb();
        send(3);
        @(negedge clk); in_valid = 1'b0; l[2] = led;
        @(negedge clk); l[1] = led;
        @(negedge clk); l[0] = led; rise_c = cyc;
        checks++; if (l !== 3'b001) begin errors++; $display("FAIL t1_latency led_after_E0..E2 got=%b want=001", l); end
        wait_idle(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t1_idle busy still 1, want 0"); end
        checks++; if (cyc - rise_c !== 52 + TAIL) begin errors++; $display("FAIL t1_rise_to_idle got=%0d want=%0d", cyc - rise_c, 52 + TAIL); end
        checks++; if (cyc - fall_cyc !== TAIL) begin errors++; $display("FAIL t1_tail got=%0d want=%0d", cyc - fall_cyc, TAIL); end
        while (exp_marks.size() > 0) begin
            int e, o;
            e = exp_marks.pop_front(); o = -1;
            if (obs_marks.size() > 0) o = obs_marks.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t1_mark got=%0d want=%0d", o, e); end
        end
        while (exp_gaps.size() > 0) begin
            int e, o;
            e = exp_gaps.pop_front(); o = -1;
            if (obs_gaps.size() > 0) o = obs_gaps.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t1_gap got=%0d want=%0d", o, e); end
        end
        checks++; if (obs_marks.size() + obs_gaps.size() != 0) begin errors++; $display("FAIL t1_extra got=%0d extra events want=0", obs_marks.size() + obs_gaps.size()); end
    endtask

    task automatic test_back_to_back();
        int c1, c2, c3;
        bit ok, busy_at_zero;
        clear_sb();
        send(0);
        #1 c1 = fifo_count;
        send(5);
        @(negedge clk); in_valid = 1'b0; c2 = fifo_count;
        @(negedge clk); c3 = fifo_count;
        checks++; if (c1 !== 1 || c2 !== 2 || c3 !== 1) begin errors++; $display("FAIL t2_count_seq got=%0d,%0d,%0d want=1,2,1", c1, c2, c3); end
        ok = 0; busy_at_zero = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (fifo_count == 3'd0) begin ok = 1; busy_at_zero = busy; end
        end
        checks++; if (!ok || !busy_at_zero) begin errors++; $display("FAIL t2_count_zero reached=%b busy=%b want 1,1", ok, busy_at_zero); end
        wait_idle(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t2_idle busy still 1, want 0"); end
        while (exp_marks.size() > 0) begin
            int e, o;
            e = exp_marks.pop_front(); o = -1;
            if (obs_marks.size() > 0) o = obs_marks.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t2_mark got=%0d want=%0d", o, e); end
        end
        while (exp_gaps.size() > 0) begin
            int e, o;
            e = exp_gaps.pop_front(); o = -1;
            if (obs_gaps.size() > 0) o = obs_gaps.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t2_gap got=%0d want=%0d", o, e); end
        end
        checks++; if (obs_marks.size() + obs_gaps.size() != 0) begin errors++; $display("FAIL t2_extra got=%0d extra events want=0", obs_marks.size() + obs_gaps.size()); end
    endtask

    task automatic test_fifo_full();
        bit ok;
        clear_sb();
        send(1);
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < 20 && !led; i++) @(negedge clk);
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL t3_keying led=%b want=1", led); end
        send(2); send(8); send(9); send(4);
        #1;
        checks++; if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL t3_full count=%0d ready=%b want=4,0", fifo_count, in_ready); end
        @(negedge clk); digit_in = 4'd6;
        repeat (10) @(negedge clk);
        checks++; if (fifo_count !== 3'd4 || in_ready !== 1'b0 || bad_digit !== 1'b0) begin errors++; $display("FAIL t3_held count=%0d ready=%b bad=%b want=4,0,0", fifo_count, in_ready, bad_digit); end
        send(6);
        #1;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL t3_refill count=%0d want=4", fifo_count); end
        @(negedge clk); in_valid = 1'b0;
        wait_idle(2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t3_idle busy still 1, want 0"); end
        while (exp_marks.size() > 0) begin
            int e, o;
            e = exp_marks.pop_front(); o = -1;
            if (obs_marks.size() > 0) o = obs_marks.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t3_mark got=%0d want=%0d", o, e); end
        end
        while (exp_gaps.size() > 0) begin
            int e, o;
            e = exp_gaps.pop_front(); o = -1;
            if (obs_gaps.size() > 0) o = obs_gaps.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t3_gap got=%0d want=%0d", o, e); end
        end
        checks++; if (obs_marks.size() + obs_gaps.size() != 0) begin errors++; $display("FAIL t3_extra got=%0d extra events want=0", obs_marks.size() + obs_gaps.size()); end
    endtask

    task automatic test_bad_digit();
        logic b0, b1, b2;
        @(negedge clk); b0 = bad_digit; in_valid = 1'b1; digit_in = 4'd12;
        @(negedge clk); in_valid = 1'b0; b1 = bad_digit;
        @(negedge clk); b2 = bad_digit;
        checks++; if ({b0, b1, b2} !== 3'b010) begin errors++; $display("FAIL t4_pulse got=%b%b%b want=010", b0, b1, b2); end
        checks++; if (fifo_count !== 3'd0 || led !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t4_nostore count=%0d led=%b busy=%b want=0,0,0", fifo_count, led, busy); end
    endtask

    task automatic test_abort();
        clear_sb();
        send(7); send(3); send(9);
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < 20 && !led; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        checks++; if (led !== 1'b1 || fifo_count !== 3'd2) begin errors++; $display("FAIL t5_middash led=%b count=%0d want=1,2", led, fifo_count); end
        abort = 1'b1;
        @(posedge clk); #1;
        checks++; if (led !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL t5_flush led=%b count=%0d busy=%b want=0,0,0", led, fifo_count, busy); end
        @(negedge clk); abort = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (led !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t5_stay_idle led=%b busy=%b want=0,0", led, busy); end
        clear_sb();
    endtask

    task automatic test_reset_and_word_gap();
        bit ok;
        clear_sb();
        send(8);
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < 20 && !led; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (led !== 1'b0 || busy !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL t6_async_reset led=%b busy=%b count=%0d want=0,0,0", led, busy, fifo_count); end
        @(negedge clk); @(negedge clk); rst = 1'b1;
        clear_sb();
        send(1);
        @(negedge clk); in_valid = 1'b0;
        wait_idle(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL t6_idle busy still 1, want 0"); end
        checks++; if (cyc - fall_cyc !== TAIL) begin errors++; $display("FAIL t6_tail got=%0d want=%0d", cyc - fall_cyc, TAIL); end
        while (exp_marks.size() > 0) begin
            int e, o;
            e = exp_marks.pop_front(); o = -1;
            if (obs_marks.size() > 0) o = obs_marks.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t6_mark got=%0d want=%0d", o, e); end
        end
        while (exp_gaps.size() > 0) begin
            int e, o;
            e = exp_gaps.pop_front(); o = -1;
            if (obs_gaps.size() > 0) o = obs_gaps.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t6_gap got=%0d want=%0d", o, e); end
        end
        checks++; if (obs_marks.size() + obs_gaps.size() != 0) begin errors++; $display("FAIL t6_extra got=%0d extra events want=0", obs_marks.size() + obs_gaps.size()); end
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_back_to_back();
        test_fifo_full();
        test_bad_digit();
        test_abort();
        test_reset_and_word_gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
